dac_playback_ctrl: RTL
======================

# dac_playback_ctrl

Playback sequencer that feeds the 256-bit multi-channel DAC datapath. It reads waveform words from a synchronous waveform memory (1-cycle read latency) and streams them on an AXI-Stream master. It supports a configurable base address, length and repeat count. A 2-entry prefetch buffer sustains one word per cycle under full throughput and absorbs downstream backpressure without dropping or duplicating words.

## Interface
- BITS, 256, stream/memory word width (16 DAC channels × 16 bits)
- ADDR_W, 10, waveform memory address width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin playback; honored only in IDLE
- stop  in  1  single-cycle request to end playback after the current pass
- cfg_base  in  ADDR_W  first word address; sampled on accepted start
- cfg_len  in  ADDR_W  words per pass, 1..2^ADDR_W-1; sampled on accepted start
- cfg_repeat  in  8  pass count; 0 = repeat until stop
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  BITS  read data, valid the cycle after mem_rd_en
- m_axis_tdata  out  BITS  stream data to DAC datapath
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  marks the last word of each pass
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse when playback completes

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start with cfg_len != 0; start with cfg_len == 0 is ignored (stays IDLE, no done).
- On accepted start: latch base, len, repeat; clear stop_pending; set the address pointer to base and the word/pass counters to 0.
- RUN: issue a read when (buffer occupancy + reads in flight − pop this cycle) < 2.
  - Each read increments the pointer.
  - After len reads the pointer reloads base and the pass counter increments.
  - Addresses are modulo 2^ADDR_W, so base+len may wrap past the top of memory.
- Each read carries a last flag set on word len−1 of its pass. The flag travels with the word through the buffer to m_axis_tlast.
- RUN -> DRAIN once the final read is issued. The final read is the last word of pass cfg_repeat, or the last word of the current pass if stop_pending is set. No further reads are issued in DRAIN.
- stop in RUN sets stop_pending. The current pass completes in full with tlast and no truncation. A stop arriving during the last word's read cycle still completes that pass only. stop in IDLE/DRAIN is ignored.
- DRAIN -> IDLE the cycle after the final word's handshake (tvalid & tready & tlast). done pulses for 1 cycle in IDLE's first cycle; busy is low in that same cycle.
- start while busy: ignored, config unchanged.
- AXI rule: once tvalid is high, tdata/tlast are held stable until the handshake. tvalid never drops without a handshake.
- Buffer: 2-entry FIFO; push on the mem_rd_data return cycle, pop on handshake. Simultaneous push and pop at occupancy 1 or 2 is legal. Overflow is impossible by the issue rule.

## Timing
- Reset (async assert, sync release): state IDLE. mem_rd_en, mem_addr, m_axis_tvalid, m_axis_tlast, busy and done are 0; m_axis_tdata is 0; buffer is empty; in-flight reads are discarded.
- start accepted in cycle 0:
  - busy = 1 and mem_rd_en = 1 with mem_addr = base in cycle 1.
  - Data returns in cycle 2; m_axis_tvalid = 1 in cycle 3.
  - Latency start→first tvalid is 3 cycles.
- With tready held high: one word per cycle continuously, including across pass boundaries (no bubble at the base reload).
- tready low: reads stall within 1 cycle once 2 words are buffered or in flight. Resuming tready restores full rate with no lost word.
- Reset mid-stream: outputs return to reset values immediately. No done pulse.

## Test plan
- base=0x010, len=4, repeat=1, tready=1 -> tvalid cycles 3..6; addresses 0x010..0x013 in order; tlast only on word 4; done in cycle 7, busy low in cycle 7.
- Same config, tready toggling 1,0,0,1,… -> all 4 words delivered exactly once, in order; tdata stable while tvalid & !tready; the memory is never read more than 2 ahead.
- base=0x3FE, len=4, repeat=3, tready=1 -> address sequence 3FE,3FF,000,001 repeated 3 times; 12 contiguous valid cycles; tlast on words 4, 8 and 12; done once.
- repeat=0, len=5, stop pulsed on the 7th handshake -> stream ends after word 10 (tlast); done follows; no reads issued after the 10th.
- start with cfg_len=0 -> no reads, busy and done stay 0. A second start while busy with different cfg -> ignored; original sequence completes unchanged.
- rst_n asserted after 3 handshakes of a len=8 run -> tvalid, busy and mem_rd_en drop immediately. A subsequent start replays from the new base, with no stale buffered word emitted.

Source files
------------

// File: rtl/dac_playback_ctrl.sv
// dac_playback_ctrl: sequences waveform-memory reads into an AXI-Stream master (base/len/repeat).
// Latency: 3 cycles from accepted start to first tvalid; one word per cycle sustained.
// Backpressure: 2-entry prefetch buffer; reads stall once 2 words are buffered or in flight.

// dac_fifo: small generic synchronous FIFO (DEPTH must be a power of two).
// Latency: pushed word is visible at pop_dat the cycle after push.
// Backpressure: none internally; caller guarantees no overflow or underflow.
module dac_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage and pointers; entries are cleared on reset so the head reads as zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module dac_playback_ctrl #(
  parameter int BITS   = 256,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [7:0]        cfg_repeat,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BITS-1:0]   mem_rd_data,
  output logic [BITS-1:0]   m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] word_cnt;
  logic [7:0]        rep_q;
  logic [7:0]        pass_cnt;
  logic              stop_pending;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic              done_q;
  logic [1:0]        occ;
  logic [BITS:0]     head;
  logic              accept;
  logic              pop;
  logic              issue;
  logic              rd_last;
  logic              final_rd;
  logic              drain_exit;

  assign accept  = (state == IDLE) && start && (cfg_len != '0);
  assign pop     = m_axis_tvalid && m_axis_tready;
  // Issue while buffered + in-flight words, net of this cycle's pop, stay below 2.
  assign issue   = (state == RUN) &&
                   (({1'b0, occ} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop}));
  assign rd_last = (word_cnt == len_q - ADDR_W'(1));
  // A stop arriving on the last word's read cycle still ends playback with this pass.
  assign final_rd = rd_last &&
                    (stop_pending || stop || ((rep_q != 8'd0) && (pass_cnt == rep_q - 8'd1)));
  // The final word is alone in the buffer with nothing in flight when it handshakes.
  assign drain_exit = (state == DRAIN) && pop && m_axis_tlast &&
                      (occ == 2'd1) && !rd_vld_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue && final_rd) state_nxt = DRAIN;
      DRAIN:   if (drain_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration latch, read pointer and word/pass counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q       <= '0;
      len_q        <= '0;
      rep_q        <= '0;
      ptr          <= '0;
      word_cnt     <= '0;
      pass_cnt     <= '0;
      stop_pending <= 1'b0;
    end else if (accept) begin
      base_q       <= cfg_base;
      len_q        <= cfg_len;
      rep_q        <= cfg_repeat;
      ptr          <= cfg_base;
      word_cnt     <= '0;
      pass_cnt     <= '0;
      stop_pending <= 1'b0;
    end else if (state == RUN) begin
      if (stop) stop_pending <= 1'b1;
      if (issue) begin
        if (rd_last) begin
          ptr      <= base_q;
          word_cnt <= '0;
          pass_cnt <= pass_cnt + 8'd1;
        end else begin
          ptr      <= ptr + ADDR_W'(1);
          word_cnt <= word_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Read-in-flight tracking (the last flag rides alongside the memory latency) and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue && rd_last;
      done_q    <= drain_exit;
    end
  end

  dac_fifo #(.W(BITS + 1), .DEPTH(2)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_vld_q),
    .push_dat ({rd_last_q, mem_rd_data}),
    .pop      (pop),
    .pop_dat  (head),
    .count    (occ)
  );

  assign mem_rd_en     = issue;
  assign mem_addr      = ptr;
  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = head[BITS-1:0];
  assign m_axis_tlast  = head[BITS] && m_axis_tvalid;
  assign busy          = (state != IDLE);
  assign done          = done_q;
endmodule
